// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes and memory bus shared by the two-port image memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req0, req1, we0, we1, lock0, lock1;
  logic [ADDR_W-1:0] addr0, addr1, addr;
  logic [DATA_W-1:0] wdata0, wdata1, rdata0, rdata1, dataR, dataW;
  logic              gnt0, gnt1, rvalid0, rvalid1, err0, err1, en, we;

  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, dataR,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1, addr, dataW, en, we
  );

  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1, dataR,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1, addr, dataW, en, we
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin, lockable two-port arbiter for the single-port image memory
module mem_arbiter #(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(50687)
) (
  input logic           clk,
  input logic           reset,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {UNLOCKED, LOCKED0, LOCKED1} state_t;

  state_t            state;
  logic              prio, pend0, pend1, c0, c1, ok0, ok1, rd0, rd1;
  logic [DATA_W-1:0] hold0, hold1;

  // Grant and memory drive are combinational; rdata shows live dataR on the completion cycle, then the held copy
  always_comb begin
    c0 = bus.req0 && !reset && state != LOCKED1;
    c1 = bus.req1 && !reset && state != LOCKED0;
    bus.gnt0 = c0 && (!c1 || !prio);
    bus.gnt1 = c1 && (!c0 || prio);
    ok0 = bus.addr0 <= MAX_ADDR;
    ok1 = bus.addr1 <= MAX_ADDR;
    rd0 = bus.gnt0 && !bus.we0;
    rd1 = bus.gnt1 && !bus.we1;
    bus.en = (bus.gnt0 && ok0) || (bus.gnt1 && ok1);
    bus.we = bus.en && (bus.gnt1 ? bus.we1 : bus.we0);
    bus.addr = bus.en ? (bus.gnt1 ? bus.addr1 : bus.addr0) : '0;
    bus.dataW = bus.en ? (bus.gnt1 ? bus.wdata1 : bus.wdata0) : '0;
    bus.rdata0 = pend0 ? bus.dataR : hold0;
    bus.rdata1 = pend1 ? bus.dataR : hold1;
  end

  // Ownership FSM and round-robin pointer; a dropped lock releases ownership even without a request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= UNLOCKED;
      prio  <= 1'b0;
    end else begin
      if (bus.gnt0) prio <= 1'b1;
      else if (bus.gnt1) prio <= 1'b0;
      case (state)
        LOCKED0: state <= bus.lock0 ? LOCKED0 : UNLOCKED;
        LOCKED1: state <= bus.lock1 ? LOCKED1 : UNLOCKED;
        default: state <= (bus.gnt0 && bus.lock0) ? LOCKED0 : (bus.gnt1 && bus.lock1) ? LOCKED1 : UNLOCKED;
      endcase
    end
  end

  // Response path: rvalid/err one cycle after grant; out-of-range reads complete with zero data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {bus.rvalid0, bus.rvalid1, bus.err0, bus.err1, pend0, pend1} <= '0;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      bus.rvalid0 <= rd0;
      bus.rvalid1 <= rd1;
      bus.err0 <= bus.gnt0 && !ok0;
      bus.err1 <= bus.gnt1 && !ok1;
      pend0 <= rd0 && ok0;
      pend1 <= rd1 && ok1;
      hold0 <= (rd0 && !ok0) ? '0 : pend0 ? bus.dataR : hold0;
      hold1 <= (rd1 && !ok1) ? '0 : pend1 ? bus.dataR : hold1;
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the accelerator's single-port 32-bit image memory between two requesters. Port 0 is the pixel fetch engine and port 1 is the result write-back engine. The arbiter grants at most one access per cycle using round-robin priority. It supports a lock for atomic bursts, returns read data to the issuing port one cycle later, and blocks out-of-range addresses. It sits between the edge-detection datapath engines and the memory bus (addr/dataR/dataW/en/we).

## Interface
Parameters:
- ADDR_W, 16, word address width
- DATA_W, 32, word width (4 packed 8-bit pixels)
- MAX_ADDR, 50687, highest legal word address (source image 0..25343, result image 25344..50687)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- req0 / req1  in  1  access request from port 0 / port 1
- we0 / we1  in  1  1 = write, 0 = read; valid while reqN is high
- lock0 / lock1  in  1  keep ownership after this grant (burst)
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  combinational; request accepted this cycle
- rvalid0 / rvalid1  out  1  registered; read data valid on rdataN
- rdata0 / rdata1  out  DATA_W  registered read data
- err0 / err1  out  1  registered one-cycle pulse; the granted access was out of range
- addr  out  ADDR_W  memory address
- dataR  in  DATA_W  memory read data; valid the cycle after en=1, we=0
- dataW  out  DATA_W  memory write data
- en  out  1  memory enable
- we  out  1  memory write enable

## Operation
- Ownership FSM: UNLOCKED, LOCKED0, LOCKED1. Reset state is UNLOCKED. The priority pointer prio resets to 0.
- UNLOCKED arbitration:
  - If only one port requests, that port wins.
  - If both request, port prio wins.
  - After any grant to port k, prio <= 1-k.
- LOCKEDk: only port k can be granted; the other port's req is ignored and its gnt stays 0.
- Transitions:
  - UNLOCKED -> LOCKEDk on a grant to k with lockk=1.
  - LOCKEDk -> UNLOCKED at any edge where lockk=0, whether or not port k is requesting.
  - LOCKEDk -> LOCKEDk on a grant with lockk=1.
  - The prio update still applies while locked.
- Winner k with addrk <= MAX_ADDR: en=1, we=wek, addr=addrk, dataW=wdatak, all in the same cycle.
- Winner k with addrk > MAX_ADDR: gntk=1 but en=0 and we=0, so the memory is untouched.
  - Next cycle errk=1.
  - If it was a read, rvalidk=1 with rdatak=0.
- No grant: en=0, we=0, addr=0, dataW=0.
- A read granted in cycle t produces rvalidk=1 and rdatak=dataR in cycle t+1. rdatak holds its value until the next read completion for that port.
- A requester holds reqN, weN, addrN and wdataN stable until gntN is seen. Dropping reqN withdraws the request without side effects.

## Timing
- Grant latency is 0 cycles. gntN, en, we, addr and dataW are combinational from the inputs, prio and FSM state.
- Read latency is 1 cycle from grant to rvalid. A back-to-back read every cycle is supported, giving 1 word/cycle total throughput.
- Write completes at the grant edge. No response is returned apart from err.
- Reset values: gnt0/1=0, en=0, we=0, addr=0, dataW=0, rvalid0/1=0, rdata0/1=0, err0/1=0. While reset is high all grants are forced to 0.
- Reset asserted mid-operation: the FSM returns to UNLOCKED and prio to 0. rvalid for a read granted in the cycle before reset is suppressed and never appears after reset releases.
- Simultaneous events:
  - If both request with both lockN=1 in UNLOCKED, the prio winner takes the lock.
  - If lockk falls in the same cycle port k is granted with lockk=0, the grant proceeds and the FSM returns to UNLOCKED.
- Boundary: addr=MAX_ADDR is legal; addr=MAX_ADDR+1 is out of range. Arithmetic is unsigned ADDR_W-bit comparison only.

## Test plan
- Reset, then req0 read at addr 5 with memory[5]=0x44332211: gnt0=1, en=1, we=0, addr=5 in cycle t; rvalid0=1 and rdata0=0x44332211 in t+1; rvalid1 stays 0.
- req0 and req1 held high continuously, both unlocked, for 6 cycles: grants alternate 0,1,0,1,0,1, with prio starting at 0 after reset.
- Port 1 writes addr 25344 data 0xFFEEDDCC with lock1=1 for 3 beats while req0 is held: gnt0=0 for all 3 beats. Lock1 drops on the last beat, and gnt0=1 in the following cycle.
- req0 read at addr 50688: gnt0=1, en=0; next cycle err0=1, rvalid0=1, rdata0=0; memory is not accessed. Repeating the test at addr 50687 gives a normal read with err0=0.
- Read granted in cycle t with reset pulsed in t+1: no rvalid ever appears; after release all outputs are 0, the FSM is UNLOCKED, and the first simultaneous request goes to port 0.
- Port 1 writes addr 100 data 0x000000FF while port 0 requests a read of addr 100 in the same cycle with prio=1: the write is granted first, and port 0's read in the next cycle returns 0x000000FF.
